// File: rtl/uart_tx_pkg.sv
// uart_tx shared types and frame constants.
// Build option: UART_TX_PARITY_EN adds an even parity bit.
package uart_tx_pkg;

  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_states_e;

  function automatic int frame_bits(input int dw);
    return START_BITS + dw + PARITY_BITS + STOP_BITS;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..DIV-1 while enabled, ticks on the last count.
// Shared between the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick;

  assign tick       = en_i && (cnt_q == LAST);
  assign bit_tick_o = tick;

  // next count: clear wins, wrap after the last count of a bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, data LSB first, optional parity, one stop.
// Build option: UART_TX_PARITY_EN adds an even parity bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  tx_states_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q;
  logic                  hs;
  logic                  tick;
  logic                  idle;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign hs   = valid_i && ready_q;
  assign idle = (state_q == IDLE);

  uart_baud_gen #(
    .DIV(BAUD_DIV)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (idle),
    .en_i      (!idle),
    .bit_tick_o(tick)
  );

  // frame sequencing and registered line/handshake values
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = START;
          shift_d = data_i;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    unique case (state_d)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      STOP:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= !ready_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // captured parity of the word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: loopback receiver model against a scoreboard.
// Define UART_TX_PARITY_EN for both DUT and bench to cover parity.
module tb_uart_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;

  typedef struct {
    logic [7:0] data;
    int         e0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_frames = 0;
  int   n_abort = 0;
  bit   rx_busy = 0;
  exp_t sb[$];

  uart_tx #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .DATA_WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // handshake monitor: inputs change at posedge+1, so at the
  // negedge they are what the next rising edge will see
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_i && ready_o) begin
      e.data = data_i;
      e.e0   = cyc + 1;
      sb.push_back(e);
    end
  end

  // loopback receiver: captures every cycle of a frame
  initial begin
    logic line [0:FL-1];
    logic [7:0] w;
    int   t0;
    int   bad;
    bit   ab;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_o === 1'b0) begin
        rx_busy = 1;
        t0 = cyc;
        ab = 0;
        line[0] = tx_o;
        for (int i = 1; i < FL; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            ab = 1;
            break;
          end
          line[i] = tx_o;
        end
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = sb.pop_front();
          if (ab) begin
            n_abort++;
          end else begin
            n_frames++;
            check("start_time", t0, e.e0);
            bad = 0;
            for (int b = 0; b < NB; b++)
              for (int k = 1; k < DIV; k++)
                if (line[b*DIV+k] !== line[b*DIV]) bad++;
            check("bit_length", bad, 0);
            for (int b = 0; b < 8; b++) w[b] = line[(b+1)*DIV];
            check("rx_data", w, e.data);
`ifdef UART_TX_PARITY_EN
            check("parity", line[9*DIV],
                  e.data[0]^e.data[1]^e.data[2]^e.data[3]^
                  e.data[4]^e.data[5]^e.data[6]^e.data[7]);
`endif
            check("stop_bit", line[(NB-1)*DIV], 1);
          end
        end
        rx_busy = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic wait_hs(output int e0);
    int k;
    k = 0;
    e0 = -1;
    while (k < 500) begin
      @(negedge clk);
      if (ready_o) begin
        e0 = cyc + 1;
        break;
      end
      k++;
    end
    if (e0 < 0) check("hs_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] d, output int e0);
    @(posedge clk); #1;
    data_i  = d;
    valid_i = 1'b1;
    wait_hs(e0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = $urandom_range(0, 255);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0)
        bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic ready_timing(input int e0);
    wait_cyc(e0 + FL - 1);
    check("ready_late", ready_o, 0);
    check("busy_late", busy_o, 1);
    wait_cyc(e0 + FL);
    check("ready_back", ready_o, 1);
    check("busy_back", busy_o, 0);
  endtask

  initial begin
    int e0, e1, e2;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_o, 1);
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_watch("idle_after_reset", 40);

    send(8'hA5, e0);
    wait_cyc(e0);
    check("hs_tx_low", tx_o, 0);
    check("hs_busy", busy_o, 1);
    ready_timing(e0);

    @(posedge clk); #1;
    data_i  = 8'h3C;
    valid_i = 1'b1;
    wait_hs(e1);
    @(posedge clk); #1;
    data_i = 8'hC3;
    wait_hs(e2);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("b2b_gap", e2 - e1, FL + 1);
    wait_cyc(e2 + FL + 2);

    send(8'h00, e0);
    wait_cyc(e0 + 29);
    @(posedge clk); #1;
    data_i  = 8'hFF;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_cyc(e0 + FL + 2);
    check("ignored_push", sb.size(), 0);

    send(8'h81, e0);
    wait_cyc(e0 + 44);
    @(posedge clk); #1;
    check("pre_rst_tx", tx_o, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx_o, 1);
    check("async_rst_ready", ready_o, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_watch("idle_after_abort", 150);
    check("abort_count", n_abort, 1);

`ifdef UART_TX_PARITY_EN
    send(8'h07, e0);
    ready_timing(e0);
    wait_cyc(e0 + FL + 2);
    send(8'h03, e0);
    ready_timing(e0);
    wait_cyc(e0 + FL + 2);
    check("frames_rx", n_frames, 6);
`else
    check("frames_rx", n_frames, 4);
`endif
    check("rx_idle", rx_busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
